pll_reset_ctrl: RTL and testbench
=================================

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 SHALL provide parameter RST_PULSE_CYC, default 16, PLL reset pulse length in clk cycles (min 2).
REQ-002 SHALL provide parameter LOCK_STABLE_CYC, default 1024, cycles of continuous lock required before release.
REQ-003 SHALL provide parameter LOCK_TIMEOUT_CYC, default 50000, max cycles to wait for lock after a PLL reset (1 ms at 50 MHz).
REQ-004 SHALL provide parameter MAX_RETRIES, default 3, consecutive failed lock attempts before fault.
REQ-005 SHALL have port clk  input  1  free-running reference clock, same 50 MHz source that feeds the PLL refclk.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low; one clock, no other clock domain in the block.
REQ-007 SHALL have port pll_locked  input  1  PLL lock indicator, asynchronous to clk.
REQ-008 SHALL have port force_relock  input  1  single-cycle synchronous request to restart the PLL.
REQ-009 SHALL have port pll_rst  output  1  active-high reset to the PLL rst input.
REQ-010 SHALL have port sys_rst_n  output  1  active-low reset for logic clocked by the PLL output clock.
REQ-011 SHALL have port ready  output  1  high while in RUN.
REQ-012 SHALL have port fault  output  1  high while in FAULT.
REQ-013 SHALL have port relock_cnt  output  8  count of lock losses seen in RUN, saturating at 255.

Function
REQ-014 SHALL synchronise pll_locked through two flops (locked_s); all decisions use locked_s only (2-cycle input latency).
REQ-015 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT with one shared down-counter, reloaded on every state entry.
REQ-016 PLL_RST: pll_rst=1 for exactly RST_PULSE_CYC cycles, then -> WAIT_LOCK.
REQ-017 WAIT_LOCK: locked_s=1 -> STABLE; LOCK_TIMEOUT_CYC cycles elapsed without lock -> retry counter +1, then -> PLL_RST if retries < MAX_RETRIES, else -> FAULT.
REQ-018 STABLE: locked_s held 1 for LOCK_STABLE_CYC consecutive cycles -> RUN; any locked_s=0 -> WAIT_LOCK (timeout counter reloaded, retries unchanged).
REQ-019 RUN entry SHALL clear the retry counter; sys_rst_n SHALL rise on the first RUN cycle.
REQ-020 RUN: locked_s=0 -> relock_cnt +1 (saturating), sys_rst_n=0 the following cycle, -> PLL_RST.
REQ-021 force_relock=1 in WAIT_LOCK, STABLE, RUN or FAULT -> PLL_RST with retries cleared; ignored in PLL_RST.
REQ-022 force_relock and lock loss in the same RUN cycle SHALL increment relock_cnt once and enter PLL_RST once.
REQ-023 FAULT: pll_rst=0, sys_rst_n=0, fault=1; leave only via force_relock or rst_n.
REQ-024 sys_rst_n SHALL be 0 in every state except RUN; ready SHALL equal (state==RUN); all outputs registered.
REQ-025 Counter width SHALL be clog2 of the largest of RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC; no wrap-around permitted.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=PLL_RST, pll_rst=1, sys_rst_n=0, ready=0, fault=0, relock_cnt=0, retries=0, sync flops=0, counter=RST_PULSE_CYC.
REQ-027 Deassertion of rst_n mid-operation SHALL restart the full sequence from PLL_RST; no state survives reset.

Structure
REQ-028 State enumeration and default cycle constants SHALL live in shared package pll_ctrl_pkg.
REQ-029 The two-flop synchroniser SHALL be a separate sub-module sync_2ff (reset value 0), reusable across the design.

Verification (bench parameters RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=20, MAX_RETRIES=2)
REQ-030 Release rst_n, raise pll_locked 10 cycles later -> pll_rst high exactly 4 cycles, sys_rst_n and ready rise 2+8 cycles after pll_locked, relock_cnt=0.
REQ-031 Never assert pll_locked -> two 4-cycle pll_rst pulses 20 cycles apart, then fault=1, sys_rst_n=0, pll_rst=0 held indefinitely.
REQ-032 Lock glitch low for 1 cycle in STABLE -> no release; release occurs 8 cycles after lock returns (plus sync latency).
REQ-033 Drop pll_locked in RUN -> sys_rst_n=0 within 3 cycles, relock_cnt=1, new 4-cycle pll_rst pulse; 256 losses -> relock_cnt stays 255.
REQ-034 From FAULT, pulse force_relock -> fault=0, pll_rst pulse 4 cycles, normal lock sequence completes.
REQ-035 Assert rst_n low mid-STABLE -> all outputs at reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default
// timing constants and a small helper for sizing the shared counter.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_MAX_RETRIES      = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for level signals entering the clk domain; clears to 0
// on reset so downstream logic never sees a stale level after rst_n.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock with
// timeout/retry, then releases the downstream reset; lock loss restarts it.
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_cnt,
    output pll_state_e state_dbg
);

    // Counter holds the largest load value itself, so it never needs to wrap.
    localparam int CNT_W = $clog2(max3(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC) + 1);
    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_PULSE_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(LOCK_TIMEOUT_CYC);
    // The WAIT_LOCK cycle that saw lock already counts as the first stable sample.
    localparam logic [CNT_W-1:0] STABLE_LD  = CNT_W'(LOCK_STABLE_CYC - 1);

    pll_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RET_W-1:0] retries, retries_nxt;
    logic [7:0]       relock_nxt;
    logic             locked_s;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    assign state_dbg = state;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        retries_nxt = retries;
        relock_nxt  = relock_cnt;

        case (state)
            PLL_RST: begin
                if (cnt <= CNT_ONE) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (force_relock) begin
                    state_nxt   = PLL_RST;
                    retries_nxt = '0;
                end else if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt <= CNT_ONE) begin
                    retries_nxt = retries + RET_W'(1);
                    state_nxt   = (int'(retries) + 1 < MAX_RETRIES) ? PLL_RST : FAULT;
                end
            end
            STABLE: begin
                if (force_relock) begin
                    state_nxt   = PLL_RST;
                    retries_nxt = '0;
                end else if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt <= CNT_ONE) begin
                    state_nxt   = RUN;
                    retries_nxt = '0;
                end
            end
            RUN: begin
                // Lock loss is checked first so a coincident force_relock still counts it once.
                if (!locked_s) begin
                    if (relock_cnt != 8'hFF) relock_nxt = relock_cnt + 8'd1;
                    state_nxt   = PLL_RST;
                    retries_nxt = '0;
                end else if (force_relock) begin
                    state_nxt   = PLL_RST;
                    retries_nxt = '0;
                end
            end
            FAULT: begin
                if (force_relock) begin
                    state_nxt   = PLL_RST;
                    retries_nxt = '0;
                end
            end
            default: begin
                state_nxt   = PLL_RST;
                retries_nxt = '0;
            end
        endcase

        if (state_nxt != state) begin
            case (state_nxt)
                PLL_RST:   cnt_nxt = RST_LD;
                WAIT_LOCK: cnt_nxt = TIMEOUT_LD;
                STABLE:    cnt_nxt = STABLE_LD;
                default:   cnt_nxt = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PLL_RST;
            cnt        <= RST_LD;
            retries    <= '0;
            relock_cnt <= '0;
            pll_rst    <= 1'b1;
            sys_rst_n  <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            retries    <= retries_nxt;
            relock_cnt <= relock_nxt;
            pll_rst    <= (state_nxt == PLL_RST);
            sys_rst_n  <= (state_nxt == RUN);
            ready      <= (state_nxt == RUN);
            fault      <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl with short timing parameters; a negedge
// monitor pops expected pulse lengths and event cycles pushed by the stimulus.
module tb_pll_reset_ctrl;
    import pll_ctrl_pkg::*;

    localparam int RST_P     = 4;
    localparam int STABLE_P  = 8;
    localparam int TIMEOUT_P = 20;
    localparam int RETRIES_P = 2;
    localparam int SYNC_LAT  = 2;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b1;
    logic       pll_locked   = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] relock_cnt;
    pll_state_e state_dbg;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_pulse_q[$];
    logic [31:0] exp_ready_q[$];
    logic [31:0] exp_srst_q[$];
    logic [31:0] exp_relock_q[$];
    logic [31:0] exp_fault_q[$];

    pll_reset_ctrl #(
        .RST_PULSE_CYC    (RST_P),
        .LOCK_STABLE_CYC  (STABLE_P),
        .LOCK_TIMEOUT_CYC (TIMEOUT_P),
        .MAX_RETRIES      (RETRIES_P)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .fault        (fault),
        .relock_cnt   (relock_cnt),
        .state_dbg    (state_dbg)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: cycle budget exceeded at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic relock_now();
        pll_locked = 1'b1;
        exp_ready_q.push_back(32'(cyc + SYNC_LAT + STABLE_P));
    endtask

    task automatic wait_pulse_end(input int budget);
        int n = 0;
        while (!pll_rst && n < budget) begin tick(); n++; end
        while (pll_rst && n < budget) begin tick(); n++; end
        check_eq("pulse_end_seen", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready && n < budget) begin tick(); n++; end
        check_eq("ready_seen", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_fault(input int budget);
        int n = 0;
        while (!fault && n < budget) begin tick(); n++; end
        check_eq("fault_seen", 32'(n < budget), 32'd1);
    endtask

    task automatic force_pulse(input int exp_relock);
        force_relock = 1'b1;
        pll_locked   = 1'b0;
        exp_srst_q.push_back(32'(cyc + 1));
        exp_relock_q.push_back(32'(exp_relock));
        exp_pulse_q.push_back(32'(RST_P));
        tick();
        force_relock = 1'b0;
    endtask

    task automatic lose_lock(input int exp_relock);
        pll_locked = 1'b0;
        exp_srst_q.push_back(32'(cyc + SYNC_LAT + 1));
        exp_relock_q.push_back(32'(exp_relock));
        exp_pulse_q.push_back(32'(RST_P));
        wait_pulse_end(40);
        relock_now();
        wait_ready(60);
    endtask

    task automatic check_reset_outputs(input string sfx);
        check_eq({"rst_pll_rst", sfx}, 32'(pll_rst), 32'd1);
        check_eq({"rst_sys_rst_n", sfx}, 32'(sys_rst_n), 32'd0);
        check_eq({"rst_ready", sfx}, 32'(ready), 32'd0);
        check_eq({"rst_fault", sfx}, 32'(fault), 32'd0);
        check_eq({"rst_relock_cnt", sfx}, 32'(relock_cnt), 32'd0);
    endtask

    // Scoreboard monitor
    int   plen       = 0;
    logic prev_ready = 1'b0;
    logic prev_srst  = 1'b0;
    logic prev_fault = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            plen       = 0;
            prev_ready = 1'b0;
            prev_srst  = 1'b0;
            prev_fault = 1'b0;
        end else begin
            if (pll_rst) begin
                plen++;
            end else if (plen != 0) begin
                if (exp_pulse_q.size() == 0) check_eq("pulse_unexpected", 32'(plen), 32'd0);
                else check_eq("pll_rst_len", 32'(plen), exp_pulse_q.pop_front());
                plen = 0;
            end
            if (ready && !prev_ready) begin
                if (exp_ready_q.size() == 0) check_eq("ready_unexpected", 32'(cyc), 32'd0);
                else check_eq("ready_rise_cycle", 32'(cyc), exp_ready_q.pop_front());
                check_eq("sys_rst_n_with_ready", 32'(sys_rst_n), 32'd1);
            end
            if (!sys_rst_n && prev_srst) begin
                if (exp_srst_q.size() == 0) check_eq("srst_unexpected", 32'(cyc), 32'd0);
                else check_eq("sys_rst_n_fall_cycle", 32'(cyc), exp_srst_q.pop_front());
                if (exp_relock_q.size() != 0) check_eq("relock_cnt", 32'(relock_cnt), exp_relock_q.pop_front());
            end
            if (fault && !prev_fault) begin
                if (exp_fault_q.size() == 0) check_eq("fault_unexpected", 32'(cyc), 32'd0);
                else check_eq("fault_rise_cycle", 32'(cyc), exp_fault_q.pop_front());
            end
            prev_ready = ready;
            prev_srst  = sys_rst_n;
            prev_fault = fault;
        end
    end

    initial begin
        int n_loss;
        int bad;

        // Power-on reset
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("_por");

        // Clean start: lock arrives 10 cycles after release
        rst_n = 1'b1;
        exp_pulse_q.push_back(32'(RST_P));
        repeat (10) tick();
        relock_now();
        wait_ready(60);
        check_eq("relock_after_start", 32'(relock_cnt), 32'd0);

        // Lock loss in RUN
        lose_lock(1);

        // Lock loss and force_relock in the same RUN cycle
        pll_locked = 1'b0;
        exp_srst_q.push_back(32'(cyc + SYNC_LAT + 1));
        exp_relock_q.push_back(32'd2);
        exp_pulse_q.push_back(32'(RST_P));
        tick();
        tick();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        wait_pulse_end(40);
        relock_now();
        wait_ready(60);

        // force_relock alone in RUN, then a second request inside PLL_RST is ignored
        force_pulse(2);
        tick();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        wait_pulse_end(40);
        relock_now();
        wait_ready(60);

        // One-cycle lock glitch during STABLE delays release
        force_pulse(2);
        wait_pulse_end(40);
        pll_locked = 1'b1;
        repeat (4) tick();
        pll_locked = 1'b0;
        tick();
        relock_now();
        wait_ready(60);
        check_eq("relock_after_glitch", 32'(relock_cnt), 32'd2);

        // Saturation of relock_cnt
        n_loss = 2;
        while (n_loss < 257) begin
            n_loss++;
            lose_lock((n_loss > 255) ? 255 : n_loss);
        end
        check_eq("relock_saturated", 32'(relock_cnt), 32'd255);

        // Asynchronous reset in the middle of STABLE
        force_pulse(255);
        wait_pulse_end(40);
        pll_locked = 1'b1;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("_async");
        pll_locked = 1'b0;
        repeat (2) tick();

        // No lock at all: two pulses, two timeouts, then FAULT
        rst_n = 1'b1;
        exp_pulse_q.push_back(32'(RST_P));
        exp_pulse_q.push_back(32'(RST_P));
        exp_fault_q.push_back(32'(cyc + RETRIES_P * (RST_P + TIMEOUT_P)));
        wait_fault(100);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!fault || pll_rst || sys_rst_n || ready) bad++;
        end
        check_eq("fault_hold_violations", 32'(bad), 32'd0);

        // Recovery from FAULT via force_relock
        force_relock = 1'b1;
        exp_pulse_q.push_back(32'(RST_P));
        tick();
        force_relock = 1'b0;
        check_eq("fault_cleared", 32'(fault), 32'd0);
        check_eq("pll_rst_after_force", 32'(pll_rst), 32'd1);
        wait_pulse_end(40);
        relock_now();
        wait_ready(60);
        check_eq("fault_after_recovery", 32'(fault), 32'd0);
        check_eq("relock_after_recovery", 32'(relock_cnt), 32'd0);

        repeat (3) tick();
        check_eq("pulse_q_left", 32'(exp_pulse_q.size()), 32'd0);
        check_eq("ready_q_left", 32'(exp_ready_q.size()), 32'd0);
        check_eq("srst_q_left", 32'(exp_srst_q.size()), 32'd0);
        check_eq("fault_q_left", 32'(exp_fault_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
